serial_add_sub: RTL and testbench

//  Parametrised digit-serial adder/subtractor; successor to the fixed-width ripple adders.

---
 rtl/serial_add_sub.sv | 125 ++++++++++++
 tb/tb_serial_add_sub.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB first, with
// valid/ready handshakes on the operand and result sides.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
            $error("serial_add_sub: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_digit;
    logic             accept;
    logic [DIGIT:0]   digit_sum;
    logic             msb_carry_in;

    assign accept     = in_valid && in_ready;
    assign last_digit = (cnt == CW'(NDIG - 1));

    // One digit slice of the add; the carry into the slice's top bit is recovered
    // from the sum bit so the MSB carry-in is available for overflow on the last digit.
    always_comb begin
        digit_sum    = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry};
        msb_carry_in = digit_sum[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
        res_next     = (res_reg >> DIGIT)
                     | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)     state_next = RUN;
            RUN:     if (last_digit) state_next = HOLD;
            HOLD:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == HOLD);
    end

    // Subtraction is folded into addition by inverting B and the borrow at capture time.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            s       <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= a;
                        b_reg <= b ^ {WIDTH{sub}};
                        carry <= ci ^ sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> DIGIT;
                    b_reg   <= b_reg >> DIGIT;
                    res_reg <= res_next;
                    carry   <= digit_sum[DIGIT];
                    cnt     <= cnt + CW'(1);
                    if (last_digit) begin
                        s   <= res_next;
                        co  <= digit_sum[DIGIT];
                        ovf <= msb_carry_in ^ digit_sum[DIGIT];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench: directed cases on the DIGIT=4 build, randomized comparison of
// DIGIT=4, DIGIT=16 and DIGIT=1 builds against an arithmetic reference model.
module tb_serial_add_sub;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ci;
    logic          sub;

    logic          in_ready, out_valid, co, ovf;
    logic [W-1:0]  s;
    logic          in_ready16, out_valid16, co16, ovf16;
    logic [W-1:0]  s16;
    logic          in_ready1, out_valid1, co1, ovf1;
    logic [W-1:0]  s1;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(W), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .ovf(ovf)
    );

    serial_add_sub #(.WIDTH(W), .DIGIT(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid16), .out_ready(out_ready), .s(s16), .co(co16), .ovf(ovf16)
    );

    serial_add_sub #(.WIDTH(W), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid1), .out_ready(out_ready), .s(s1), .co(co1), .ovf(ovf1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer arithmetic on the unsigned and signed views of the operands.
    function automatic void refModel(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                     input logic rci, input logic rsub,
                                     output logic [W-1:0] rs, output logic rco,
                                     output logic rovf);
        longint ua, ub, sa, sb, c, full, sv;
        ua = longint'(ra);
        ub = longint'(rb);
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        c  = rci ? 64'sd1 : 64'sd0;
        if (!rsub) begin
            full = ua + ub + c;
            rco  = (full >= 65536);
            sv   = sa + sb + c;
        end else begin
            full = ua - ub - c;
            rco  = (ua >= ub + c);
            sv   = sa - sb - c;
        end
        rs   = full[W-1:0];
        rovf = (sv > 32767) || (sv < -32768);
    endfunction

    // Waits until every build is idle, then presents one operation for a single edge.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_val,
                                 input logic tci, input logic tsub);
        int guard;
        guard = 0;
        while (!(in_ready && in_ready16 && in_ready1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_before_accept", {61'd0, in_ready, in_ready16, in_ready1}, 64'h7);
        a        = ta;
        b        = tb_val;
        ci       = tci;
        sub      = tsub;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic directedOp(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_val,
                              input logic tci, input logic tsub);
        logic [W-1:0] es;
        logic         eco, eovf;
        int           lat;
        refModel(ta, tb_val, tci, tsub, es, eco, eovf);
        applyStimulus(ta, tb_val, tci, tsub);
        waitResult(lat);
        checkOutput({tag, "_latency"}, 64'(lat), 64'd4);
        checkOutput({tag, "_s"}, 64'(s), 64'(es));
        checkOutput({tag, "_co"}, 64'(co), 64'(eco));
        checkOutput({tag, "_ovf"}, 64'(ovf), 64'(eovf));
    endtask

    initial begin
        logic [W-1:0] es;
        logic         eco, eovf;
        int           lat;
        logic [W-1:0] ra, rb;
        logic         rci, rsub;
        logic         got_m, got_16, got_1;
        int           lat_m, lat_16, lat_1;
        logic [W-1:0] sv_m, sv_16, sv_1;
        logic         co_m, co_16, co_1, ov_m, ov_16, ov_1;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        a        = 16'hABCD;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_s", 64'(s), 64'd0);
        checkOutput("reset_co", 64'(co), 64'd0);
        checkOutput("reset_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_idle", 64'(out_valid), 64'd0);

        $display("[TB] directed cases");
        directedOp("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        directedOp("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        directedOp("add_ci", 16'h1234, 16'h4321, 1'b1, 1'b0);
        directedOp("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b0 | 1'b1);
        directedOp("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1);
        directedOp("sub_borrow", 16'h0000, 16'h0000, 1'b1, 1'b1);

        $display("[TB] backpressure");
        refModel(16'h9ABC, 16'h1357, 1'b1, 1'b0, es, eco, eovf);
        applyStimulus(16'h9ABC, 16'h1357, 1'b1, 1'b0);
        out_ready = 1'b0;
        waitResult(lat);
        checkOutput("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            ci       = 1'($urandom);
            sub      = 1'($urandom);
            @(negedge clk);
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_s", 64'(s), 64'(es));
            checkOutput("bp_co_ovf", {62'd0, co, ovf}, {62'd0, eco, eovf});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
        checkOutput("bp_s_retained", 64'(s), 64'(es));
        @(negedge clk);
        checkOutput("bp_no_ghost_op", 64'(out_valid), 64'd0);

        $display("[TB] reset abort");
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_s_cleared", 64'(s), 64'd0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("abort_no_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        directedOp("after_abort", 16'h4000, 16'h4000, 1'b0, 1'b0);

        $display("[TB] randomized comparison of DIGIT=4/16/1 builds");
        for (int n = 0; n < 40; n++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rci  = 1'($urandom);
            rsub = 1'($urandom);
            if (n % 8 == 0) rb = ra;
            if (n % 8 == 1) begin ra = 16'h8000; rb = 16'h7FFF; end
            refModel(ra, rb, rci, rsub, es, eco, eovf);
            applyStimulus(ra, rb, rci, rsub);
            got_m = 1'b0; got_16 = 1'b0; got_1 = 1'b0;
            lat_m = 0; lat_16 = 0; lat_1 = 0;
            sv_m = '0; sv_16 = '0; sv_1 = '0;
            co_m = 1'b0; co_16 = 1'b0; co_1 = 1'b0;
            ov_m = 1'b0; ov_16 = 1'b0; ov_1 = 1'b0;
            for (int k = 1; k <= 40 && !(got_m && got_16 && got_1); k++) begin
                @(negedge clk);
                if (out_valid && !got_m) begin
                    got_m = 1'b1; lat_m = k; sv_m = s; co_m = co; ov_m = ovf;
                end
                if (out_valid16 && !got_16) begin
                    got_16 = 1'b1; lat_16 = k; sv_16 = s16; co_16 = co16; ov_16 = ovf16;
                end
                if (out_valid1 && !got_1) begin
                    got_1 = 1'b1; lat_1 = k; sv_1 = s1; co_1 = co1; ov_1 = ovf1;
                end
            end
            checkOutput("rnd_d4_latency", 64'(lat_m), 64'd4);
            checkOutput("rnd_d4_s", 64'(sv_m), 64'(es));
            checkOutput("rnd_d4_co", 64'(co_m), 64'(eco));
            checkOutput("rnd_d4_ovf", 64'(ov_m), 64'(eovf));
            checkOutput("rnd_d16_latency", 64'(lat_16), 64'd1);
            checkOutput("rnd_d16_s", 64'(sv_16), 64'(es));
            checkOutput("rnd_d16_co", 64'(co_16), 64'(eco));
            checkOutput("rnd_d16_ovf", 64'(ov_16), 64'(eovf));
            checkOutput("rnd_d1_latency", 64'(lat_1), 64'd16);
            checkOutput("rnd_d1_s", 64'(sv_1), 64'(es));
            checkOutput("rnd_d1_co", 64'(co_1), 64'(eco));
            checkOutput("rnd_d1_ovf", 64'(ov_1), 64'(eovf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
